// File: rtl/q2a03_bus_responder.sv
// -----------------------------------------------------------------------------
// q2a03_bus_responder
//
// Target-side responder for the Q2A03 CPU bus. The CPU address is decoded on
// every phy2 rising edge. Addresses below $2000 hit a 2^RAM_AW byte internal
// RAM that is mirrored across $0000-$1FFF. Every other address is forwarded to
// the external memory port over a req/ack handshake, with G_ready held low
// (freezing the CPU phase) until the handshake completes or times out.
//
// Configuration macro:
//   Q2A03_OPEN_BUS_EN  defined   -> a timed-out read keeps the previous G_rd_data
//                      undefined -> a timed-out read returns 8'hFF
//
// Parameters:
//   RAM_AW       internal RAM address width (default 11 -> 2 KiB)
//   EXT_TIMEOUT  clocks ext_req may stay high without ext_ack (1..65535)
//
// Ports:
//   G_clock, G_reset         clock, synchronous active-high reset
//   G_addr, G_rdwr,          CPU address, 1 = read / 0 = write,
//   G_wr_data, G_phy2        CPU write data, CPU phase-2
//   G_rd_data, G_ready       read data to the CPU, 0 = stall the CPU
//   ext_req, ext_we,         external request, 1 = write,
//   ext_addr, ext_wdata      external address and write data
//   ext_rdata, ext_ack       external read data, one-clock completion pulse
//   err_timeout              sticky external-timeout flag
// -----------------------------------------------------------------------------
module q2a03_bus_responder #(
    parameter int RAM_AW      = 11,
    parameter int EXT_TIMEOUT = 255
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    input  logic        G_phy2,
    output logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_RD,
        S_RAM_WR,
        S_EXT_REQ,
        S_WAIT_FALL
    } state_t;

    state_t      state_q, state_d;
    logic        phy2_q;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        ready_q, ready_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_pend_q, rd_pend_d;

    logic [7:0]        ram [0:(2**RAM_AW)-1];
    logic [7:0]        ram_dout_q;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_idx;
    logic              rise, fall, is_ram;

    assign rise    = G_phy2 & ~phy2_q;
    assign fall    = ~G_phy2 & phy2_q;
    assign is_ram  = (G_addr < 16'h2000);
    // Dropping the upper address bits is what produces the 4x mirror.
    assign ram_idx = G_addr[RAM_AW-1:0];

    always_comb begin
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        ready_d     = ready_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rd_pend_d   = 1'b0;
        ram_we      = 1'b0;

        // RAM read pipeline: array read registered on rise+1, presented on rise+2.
        if (rd_pend_q) begin
            rd_data_d = ram_dout_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    if (is_ram) begin
                        state_d = G_rdwr ? S_RAM_RD : S_RAM_WR;
                    end else begin
                        state_d     = S_EXT_REQ;
                        ext_addr_d  = G_addr;
                        ext_we_d    = ~G_rdwr;
                        ext_wdata_d = G_wr_data;
                        ext_req_d   = 1'b1;
                        ready_d     = 1'b0;
                        cnt_d       = 16'(EXT_TIMEOUT);
                    end
                end
            end
            S_RAM_RD: begin
                rd_pend_d = 1'b1;
                state_d   = S_WAIT_FALL;
            end
            S_RAM_WR: begin
                // The CPU holds write data valid up to the fall clock.
                if (fall) begin
                    ram_we  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXT_REQ: begin
                // Ack wins over a timeout expiring on the same clock.
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    ready_d   = 1'b1;
                    if (!ext_we_q) begin
                        rd_data_d = ext_rdata;
                    end
                    state_d = S_WAIT_FALL;
                end else if (cnt_q <= 16'd1) begin
                    // Counter reaches zero on this clock: abandon the access.
                    ext_req_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
`ifdef Q2A03_OPEN_BUS_EN
                    rd_data_d = rd_data_q;
`else
                    if (!ext_we_q) begin
                        rd_data_d = 8'hFF;
                    end
`endif
                    state_d = S_WAIT_FALL;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge G_clock) begin
        if (G_reset) begin
            state_q     <= S_IDLE;
            phy2_q      <= 1'b0;
            rd_data_q   <= 8'h00;
            ready_q     <= 1'b1;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            err_q       <= 1'b0;
            cnt_q       <= 16'h0000;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phy2_q      <= G_phy2;
            rd_data_q   <= rd_data_d;
            ready_q     <= ready_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // RAM array is not reset; its contents survive G_reset.
    always_ff @(posedge G_clock) begin
        ram_dout_q <= ram[ram_idx];
        if (ram_we) begin
            ram[ram_idx] <= G_wr_data;
        end
    end

    assign G_rd_data   = rd_data_q;
    assign G_ready     = ready_q;
    assign ext_req     = ext_req_q;
    assign ext_we      = ext_we_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wdata   = ext_wdata_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_q2a03_bus_responder.sv
module tb_q2a03_bus_responder;

    localparam int T = 4;

    logic        G_clock = 1'b0;
    logic        G_reset = 1'b1;
    logic [15:0] G_addr = 16'h0000;
    logic        G_rdwr = 1'b1;
    logic [7:0]  G_wr_data = 8'h00;
    logic        G_phy2 = 1'b0;
    logic [7:0]  G_rd_data;
    logic        G_ready;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata = 8'h00;
    logic        ext_ack = 1'b0;
    logic        err_timeout;

    q2a03_bus_responder #(.RAM_AW(11), .EXT_TIMEOUT(T)) dut (
        .G_clock(G_clock), .G_reset(G_reset), .G_addr(G_addr), .G_rdwr(G_rdwr),
        .G_wr_data(G_wr_data), .G_phy2(G_phy2), .G_rd_data(G_rd_data),
        .G_ready(G_ready), .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .ext_ack(ext_ack), .err_timeout(err_timeout)
    );

    always #5 G_clock = ~G_clock;

    int checks = 0;
    int errors = 0;

    // Reference model: 2 KiB byte array, the CPU-visible read register, sticky error.
    logic [7:0] mram [0:2047];
    bit         mvalid [0:2047];
    int         written[$];
    logic [7:0] m_rd = 8'h00;
    logic       m_err = 1'b0;

    task automatic tick();
        @(posedge G_clock);
        #1;
    endtask

    // One CPU bus cycle: phy2 high (extended while stalled), then low.
    // ack_k = number of clocks after ext_req rises before ext_ack is driven; <0 = never.
    task automatic bus_op(input logic [15:0] addr, input logic rd, input logic [7:0] wdata,
                          input int ack_k, input logic [7:0] rdata);
        int off;
        int lowcnt;
        int reqcnt;
        int j;
        int exp_low;
        bit acked;
        off = int'(addr) % 2048;
        G_addr = addr; G_rdwr = rd; G_wr_data = wdata; G_phy2 = 1'b1;
        tick();
        if (addr < 16'h2000) begin
            checks++;
            if (G_ready !== 1'b1 || ext_req !== 1'b0) begin
                errors++;
                $display("FAIL ram_rise_hs addr=%h ready=%b req=%b expected ready=1 req=0", addr, G_ready, ext_req);
            end
            tick();
            if (rd) begin
                checks++;
                if (G_rd_data !== m_rd) begin
                    errors++;
                    $display("FAIL ram_rd_early addr=%h got %h expected %h", addr, G_rd_data, m_rd);
                end
            end
            tick();
            if (rd) begin
                m_rd = mram[off];
                checks++;
                if (G_rd_data !== m_rd) begin
                    errors++;
                    $display("FAIL ram_rd_data addr=%h got %h expected %h", addr, G_rd_data, m_rd);
                end
            end
            tick(); tick(); tick();
            G_phy2 = 1'b0;
            tick();
            if (!rd) begin
                mram[off] = wdata;
                if (!mvalid[off]) written.push_back(off);
                mvalid[off] = 1'b1;
            end
            checks++;
            if (G_rd_data !== m_rd || G_ready !== 1'b1 || ext_req !== 1'b0) begin
                errors++;
                $display("FAIL ram_end addr=%h rd_data=%h ready=%b req=%b expected %h 1 0", addr, G_rd_data, G_ready, ext_req, m_rd);
            end
        end else begin
            checks++;
            if (ext_req !== 1'b1 || G_ready !== 1'b0 || ext_addr !== addr || ext_we !== ~rd
                || (!rd && ext_wdata !== wdata)) begin
                errors++;
                $display("FAIL ext_start addr=%h req=%b ready=%b eaddr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                         addr, ext_req, G_ready, ext_addr, ext_we, ext_wdata, addr, ~rd, wdata);
            end
            lowcnt = (G_ready === 1'b0) ? 1 : 0;
            reqcnt = (ext_req === 1'b1) ? 1 : 0;
            j = 0;
            while (G_ready === 1'b0 && j < 20) begin
                if (j == ack_k) begin
                    ext_ack = 1'b1; ext_rdata = rdata;
                end else begin
                    ext_rdata = 8'($urandom);
                end
                tick();
                ext_ack = 1'b0;
                if (G_ready === 1'b0) lowcnt++;
                if (ext_req === 1'b1) reqcnt++;
                j++;
            end
            acked   = (ack_k >= 0 && ack_k < T);
            exp_low = acked ? ack_k + 1 : T;
            if (rd) begin
`ifdef Q2A03_OPEN_BUS_EN
                m_rd = acked ? rdata : m_rd;
`else
                m_rd = acked ? rdata : 8'hFF;
`endif
            end
            if (!acked) m_err = 1'b1;
            checks++;
            if (lowcnt != exp_low || reqcnt != exp_low) begin
                errors++;
                $display("FAIL ext_stall_len addr=%h ready_low=%0d req_high=%0d expected %0d", addr, lowcnt, reqcnt, exp_low);
            end
            checks++;
            if (G_rd_data !== m_rd || err_timeout !== m_err || ext_req !== 1'b0) begin
                errors++;
                $display("FAIL ext_done addr=%h rd_data=%h err=%b req=%b expected %h %b 0", addr, G_rd_data, err_timeout, ext_req, m_rd, m_err);
            end
            tick(); tick();
            G_phy2 = 1'b0;
            tick();
        end
        // Stray ack while idle must be ignored.
        ext_ack = 1'b1; ext_rdata = 8'($urandom);
        tick();
        ext_ack = 1'b0;
        tick(); tick();
        checks++;
        if (G_rd_data !== m_rd || ext_req !== 1'b0 || G_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after addr=%h rd_data=%h req=%b ready=%b expected %h 0 1", addr, G_rd_data, ext_req, G_ready, m_rd);
        end
    endtask

    task automatic test_reset();
        G_reset = 1'b1; G_phy2 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (G_rd_data !== 8'h00 || G_ready !== 1'b1 || ext_req !== 1'b0 || ext_we !== 1'b0
            || ext_addr !== 16'h0000 || ext_wdata !== 8'h00 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_values rd=%h ready=%b req=%b we=%b addr=%h wd=%h err=%b expected 00 1 0 0 0000 00 0",
                     G_rd_data, G_ready, ext_req, ext_we, ext_addr, ext_wdata, err_timeout);
        end
        G_reset = 1'b0;
        tick(); tick();
        m_rd = 8'h00; m_err = 1'b0;
    endtask

    task automatic test_ram_mirror();
        bus_op(16'h0002, 1'b0, 8'h5A, -1, 8'h00);
        bus_op(16'h1802, 1'b1, 8'h00, -1, 8'h00);
        bus_op(16'h1000, 1'b0, 8'hC3, -1, 8'h00);
        bus_op(16'h0800, 1'b1, 8'h00, -1, 8'h00);
        bus_op(16'h0000, 1'b1, 8'h00, -1, 8'h00);
        bus_op(16'h1800, 1'b1, 8'h00, -1, 8'h00);
    endtask

    task automatic test_ext_read();
        bus_op(16'h8000, 1'b1, 8'h00, 3, 8'hA9);
    endtask

    task automatic test_ext_write();
        bus_op(16'h4014, 1'b0, 8'h1E, 0, 8'h77);
    endtask

    task automatic test_timeout();
        bus_op(16'h6000, 1'b1, 8'h00, -1, 8'h00);
        bus_op(16'hC000, 1'b1, 8'h00, 2, 8'h3C);
        bus_op(16'h7000, 1'b0, 8'h99, -1, 8'h00);
    endtask

    task automatic test_boundary();
        bus_op(16'h1FFF, 1'b0, 8'hE7, -1, 8'h00);
        bus_op(16'h1FFF, 1'b1, 8'h00, -1, 8'h00);
        bus_op(16'h2000, 1'b1, 8'h00, 1, 8'h42);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op;
            int k;
            op = int'($urandom_range(0, 3));
            k  = int'($urandom_range(0, 5)) - 1;
            if (k == T) k = -1;
            case (op)
                0: bus_op(16'($urandom_range(0, 16'h1FFF)), 1'b0, 8'($urandom), -1, 8'h00);
                1: begin
                    int off;
                    off = written[$urandom_range(0, written.size() - 1)];
                    bus_op(16'(off + 2048 * int'($urandom_range(0, 3))), 1'b1, 8'h00, -1, 8'h00);
                end
                2: bus_op(16'($urandom_range(16'h2000, 16'hFFFF)), 1'b1, 8'h00, k, 8'($urandom));
                default: bus_op(16'($urandom_range(16'h2000, 16'hFFFF)), 1'b0, 8'($urandom), k, 8'($urandom));
            endcase
        end
    endtask

    task automatic test_reset_mid_stall();
        G_addr = 16'h9000; G_rdwr = 1'b1; G_phy2 = 1'b1;
        tick();
        checks++;
        if (ext_req !== 1'b1 || G_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_start req=%b ready=%b expected 1 0", ext_req, G_ready);
        end
        tick(); tick();
        G_reset = 1'b1; G_phy2 = 1'b0;
        tick();
        checks++;
        if (ext_req !== 1'b0 || G_ready !== 1'b1 || err_timeout !== 1'b0 || G_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_stall_reset req=%b ready=%b err=%b rd=%h expected 0 1 0 00", ext_req, G_ready, err_timeout, G_rd_data);
        end
        G_reset = 1'b0;
        m_rd = 8'h00; m_err = 1'b0;
        tick(); tick();
        bus_op(16'h1802, 1'b1, 8'h00, -1, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mram[i] = 8'h00;
            mvalid[i] = 1'b0;
        end
        test_reset();
        test_ram_mirror();
        test_ext_read();
        test_ext_write();
        test_timeout();
        test_boundary();
        test_random();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
